pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the pipelined CPU fetch stage. It replaces the fixed PC+4 incrementer with a registered PC that advances by a configurable step, holds on stall, and takes prioritised redirects (exception, branch, return, jump/call). A small circular return-address stack (RAS) predicts the targets of procedure returns. It sits between hazard/branch resolution logic and instruction memory; `pc` drives the I-memory address.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/ras_stack.sv | 62 ++++++
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU fetch-stage definitions: default vectors and the next-PC source select.
package cpu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;

    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_BR,
        SEL_RET,
        SEL_JMP,
        SEL_HOLD,
        SEL_SEQ
    } next_sel_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; push overwrites the oldest entry when full.
// Top read is combinational from the pointer; count and flags are registered.
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_dat,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int           PW       = $clog2(DEPTH);
    localparam logic [PW:0]  FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [PW:0]      r_cnt;
    logic             r_empty;
    logic             r_full;
    logic [PW-1:0]    w_top_idx;
    logic [PW:0]      w_cnt_nxt;

    // Pointer addresses the next free slot, so the top lives one below it.
    assign w_top_idx = r_ptr - PW'(1);
    assign top       = r_mem[w_top_idx];
    assign empty     = r_empty;
    assign full      = r_full;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (push) begin
            if (r_cnt != FULL_CNT) w_cnt_nxt = r_cnt + (PW+1)'(1);
        end else if (pop && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (push) begin
                r_mem[r_ptr] <= push_dat;
                r_ptr        <= r_ptr + PW'(1);
            end else if (pop && (r_cnt != '0)) begin
                r_ptr <= r_ptr - PW'(1);
            end
            r_cnt   <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == FULL_CNT);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with prioritised redirects and a return-address stack.
// pc updates one cycle after inputs are sampled; pc_next/pc_plus_step are combinational.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEF),
    parameter int               RAS_DEPTH    = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exc_req,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] link_addr,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             misaligned,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow
);
    localparam int STEP_BITS = $clog2(STEP);

    next_sel_t        w_sel;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_push;
    logic             w_pop;
    logic             r_underflow;

    always_comb begin
        w_sel = SEL_SEQ;
        if (exc_req)           w_sel = SEL_EXC;
        else if (br_taken)     w_sel = SEL_BR;
        else if (ret)          w_sel = SEL_RET;
        else if (jump || call) w_sel = SEL_JMP;
        else if (stall)        w_sel = SEL_HOLD;
    end

    always_comb begin
        pc_next = pc_plus_step;
        case (w_sel)
            SEL_EXC:  pc_next = EXC_VECTOR;
            SEL_BR:   pc_next = br_target;
            SEL_RET:  pc_next = ras_empty ? ret_target : w_ras_top;
            SEL_JMP:  pc_next = jump_target;
            SEL_HOLD: pc_next = r_pc;
            default:  pc_next = pc_plus_step;
        endcase
    end

    // Only the winning source touches the stack.
    assign w_push = (w_sel == SEL_JMP) && call;
    assign w_pop  = (w_sel == SEL_RET) && !ras_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_VECTOR;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= pc_next;
            r_underflow <= (w_sel == SEL_RET) && ras_empty;
        end
    end

    assign pc            = r_pc;
    assign pc_plus_step  = r_pc + WIDTH'(STEP);
    assign ras_underflow = r_underflow;

    generate
        if (STEP_BITS == 0) begin : g_byte_step
            assign misaligned = 1'b0;
        end else begin : g_wide_step
            assign misaligned = |r_pc[STEP_BITS-1:0];
        end
    endgenerate

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .push_dat (link_addr),
        .top      (w_ras_top),
        .empty    (ras_empty),
        .full     (ras_full)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_pc_sequencer;

    localparam logic [31:0] EXC = 32'h8000_0180;
    localparam int          DEP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, exc_req, br_taken, jump, call, ret;
    logic [31:0] br_target, jump_target, link_addr, ret_target;
    logic [31:0] pc, pc_next, pc_plus_step;
    logic        misaligned, ras_empty, ras_full, ras_underflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit en      = 1'b0;

    logic [31:0] m_pc  = 32'h0;
    logic [31:0] m_ras [$];
    logic        m_unf = 1'b0;
    logic [31:0] m_nx;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .exc_req       (exc_req),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .link_addr     (link_addr),
        .ret           (ret),
        .ret_target    (ret_target),
        .pc            (pc),
        .pc_next       (pc_next),
        .pc_plus_step  (pc_plus_step),
        .misaligned    (misaligned),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_next();
        if (exc_req)       return EXC;
        if (br_taken)      return br_target;
        if (ret)           return (m_ras.size() == 0) ? ret_target : m_ras[m_ras.size()-1];
        if (jump || call)  return jump_target;
        if (stall)         return m_pc;
        return m_pc + 32'd4;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'h0;
            m_ras.delete();
            m_unf = 1'b0;
        end else begin
            m_nx  = model_next();
            m_unf = 1'b0;
            if (!exc_req && !br_taken && ret) begin
                if (m_ras.size() == 0) m_unf = 1'b1;
                else void'(m_ras.pop_back());
            end else if (!exc_req && !br_taken && call) begin
                m_ras.push_back(link_addr);
                if (m_ras.size() > DEP) void'(m_ras.pop_front());
            end
            m_pc = m_nx;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("m.pc",           pc,                    m_pc);
            chk("m.pc_next",      pc_next,               model_next());
            chk("m.pc_plus_step", pc_plus_step,          m_pc + 32'd4);
            chk("m.misaligned",   32'(misaligned),       32'((m_pc % 4) != 0));
            chk("m.ras_empty",    32'(ras_empty),        32'(m_ras.size() == 0));
            chk("m.ras_full",     32'(ras_full),         32'(m_ras.size() == DEP));
            chk("m.ras_underflow",32'(ras_underflow),    32'(m_unf));
        end
    end

    task automatic clr();
        stall = 0; exc_req = 0; br_taken = 0; jump = 0; call = 0; ret = 0;
        br_target = 0; jump_target = 0; link_addr = 0; ret_target = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr();
        #2 en = 1'b1;
        #21;
        chk("rst.pc",        pc,                  32'h0);
        chk("rst.pc_next",   pc_next,             32'h4);
        chk("rst.ras_empty", 32'(ras_empty),      32'h1);
        chk("rst.ras_full",  32'(ras_full),       32'h0);
        chk("rst.underflow", 32'(ras_underflow),  32'h0);
        reset = 1'b0;

        step(); chk("seq.4", pc, 32'h4);
        step(); chk("seq.8", pc, 32'h8);
        step(); chk("seq.c", pc, 32'hC);
        chk("seq.empty", 32'(ras_empty), 32'h1);
        step(); chk("seq.10", pc, 32'h10);

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall.hold", pc, 32'h10);
        end
        br_taken = 1; br_target = 32'h40;
        step(); chk("stall.br", pc, 32'h40);
        clr();

        call = 1; link_addr = 32'h300; jump_target = 32'h100;
        step(); chk("call1.pc", pc, 32'h100);
        clr();
        exc_req = 1; br_taken = 1; br_target = 32'h44; ret = 1; jump = 1; jump_target = 32'h88;
        step(); chk("exc.pc", pc, EXC);
        chk("exc.ras_kept", 32'(ras_empty), 32'h0);
        clr();
        ret = 1;
        step(); chk("exc.ret", pc, 32'h300);
        chk("exc.ret_empty", 32'(ras_empty), 32'h1);
        clr();

        call = 1; link_addr = 32'h104; jump_target = 32'h200;
        step(); chk("cr.call", pc, 32'h200);
        clr(); ret = 1;
        step(); chk("cr.ret", pc, 32'h104);
        chk("cr.empty", 32'(ras_empty), 32'h1);
        clr();

        for (int i = 0; i < 5; i++) begin
            call = 1; link_addr = 32'hA0 + 32'(i*4); jump_target = 32'h500 + 32'(i*16);
            step();
            chk("c5.pc", pc, 32'h500 + 32'(i*16));
            if (i == 2) chk("c5.notfull", 32'(ras_full), 32'h0);
            if (i == 3) chk("c5.full",    32'(ras_full), 32'h1);
        end
        clr(); ret = 1; ret_target = 32'hFF0;
        step(); chk("r5.b0", pc, 32'hB0);
        step(); chk("r5.ac", pc, 32'hAC);
        step(); chk("r5.a8", pc, 32'hA8);
        step(); chk("r5.a4", pc, 32'hA4);
        chk("r5.empty", 32'(ras_empty), 32'h1);
        chk("r5.no_unf", 32'(ras_underflow), 32'h0);
        step(); chk("r5.fallback", pc, 32'hFF0);
        chk("r5.unf", 32'(ras_underflow), 32'h1);
        clr();
        step(); chk("r5.unf_clr", 32'(ras_underflow), 32'h0);

        br_taken = 1; br_target = 32'hFFFF_FFFC;
        step(); chk("wrap.pre", pc, 32'hFFFF_FFFC);
        clr();
        step(); chk("wrap.zero", pc, 32'h0);
        br_taken = 1; br_target = 32'h42;
        step(); chk("mis.pc", pc, 32'h42);
        chk("mis.flag", 32'(misaligned), 32'h1);
        clr();

        call = 1; link_addr = 32'h77C; jump_target = 32'h600;
        step(); clr(); ret = 1;
        #2 reset = 1'b1;
        #1;
        chk("mrst.pc",    pc,             32'h0);
        chk("mrst.empty", 32'(ras_empty), 32'h1);
        #3 reset = 1'b0;
        clr();
        step(); chk("mrst.seq", pc, 32'h4);
        chk("mrst.empty2", 32'(ras_empty), 32'h1);

        for (int i = 0; i < 2000; i++) begin
            exc_req     = ($urandom_range(15) == 0);
            br_taken    = ($urandom_range(7) == 0);
            ret         = ($urandom_range(4) == 0);
            call        = ($urandom_range(3) == 0);
            jump        = ($urandom_range(7) == 0);
            stall       = ($urandom_range(3) == 0);
            br_target   = $urandom;
            jump_target = $urandom;
            link_addr   = $urandom;
            ret_target  = $urandom;
            step();
        end
        clr();
        step();

        en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
